// File: rtl/uart_rx_deframer_pkg.sv
// uart_rx_deframer_pkg: receiver FSM state encodings and error-bit positions
// shared with the future transmitter.
package uart_rx_deframer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } state_t;

    localparam int ERR_PARITY = 0;
    localparam int ERR_FRAME  = 1;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the raw rx pin plus falling-edge detect.
// All flops reset to 1 so a released reset never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rx_s = r_sync;
    assign fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: oversampling UART receiver; deframes start/data/parity/stop
// and emits either a clean byte pulse or a line-error report per frame.
module uart_rx_deframer
    import uart_rx_deframer_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic [1:0]           errors,
    output logic                 errors_valid,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    state_t               r_state;
    state_t               w_state_n;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 w_rx_s;
    logic                 w_fall;
    logic                 w_sample;
    logic                 w_frame_err;
    logic                 w_par_err;
    logic                 w_break;
    logic [1:0]           w_err;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (rx),
        .rx_s (w_rx_s),
        .fall (w_fall)
    );

    // START samples half a bit in; every later state samples one full bit later.
    assign w_sample    = r_tick == TW'(r_state == START ? OVERSAMPLE / 2 - 1 : OVERSAMPLE - 1);
    assign w_frame_err = ~w_rx_s;
    assign w_par_err   = PARITY_EN & ((^r_shift ^ r_par_bit) != PARITY_ODD);
    assign w_break     = w_frame_err & (r_shift == '0) & ~r_par_bit;
    assign busy        = r_state != IDLE;

    always_comb begin
        w_err             = '0;
        w_err[ERR_FRAME]  = w_frame_err;
        w_err[ERR_PARITY] = w_par_err & ~w_break;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:       if (w_fall) w_state_n = START;
            START:      if (w_sample) w_state_n = w_rx_s ? IDLE : DATA;
            DATA:       if (w_sample && r_bit == BW'(DATA_BITS - 1)) w_state_n = PARITY_EN ? PARITY : STOP;
            PARITY:     if (w_sample) w_state_n = STOP;
            STOP:       if (w_sample) w_state_n = w_break ? BREAK_WAIT : IDLE;
            BREAK_WAIT: if (w_rx_s) w_state_n = IDLE;
            default:    w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            data         <= '0;
            data_valid   <= 1'b0;
            errors       <= '0;
            errors_valid <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            errors_valid <= 1'b0;
            r_tick       <= (r_state == IDLE || w_sample) ? '0 : r_tick + TW'(1);
            if (r_state == START) begin
                r_bit     <= '0;
                r_par_bit <= 1'b0;
            end
            if (r_state == DATA && w_sample) begin
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                r_bit   <= r_bit + BW'(1);
            end
            if (r_state == PARITY && w_sample)
                r_par_bit <= w_rx_s;
            if (r_state == STOP && w_sample) begin
                data         <= r_shift;
                data_valid   <= ~(w_frame_err | w_par_err);
                errors_valid <= w_frame_err | w_par_err;
                if (w_frame_err | w_par_err)
                    errors <= w_err;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed frames on the rx pin at 16 clk per bit with
// hand-computed expected bytes, error codes, pulse counts and latency.
module tb_uart_rx_deframer;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic [1:0] errors;
    logic       errors_valid;
    logic       busy;

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         dv_cyc = 0;
    int         ev_n = 0;
    int         both_n = 0;
    logic [1:0] ev_last = '0;
    logic [7:0] dv_q[$];

    uart_rx_deframer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .data        (data),
        .data_valid  (data_valid),
        .errors      (errors),
        .errors_valid(errors_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_q.push_back(data);
            dv_cyc = cyc;
        end
        if (errors_valid) begin
            ev_n++;
            ev_last = errors;
        end
        if (data_valid && errors_valid) both_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (OS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int         c0;
        int         dv0;
        int         ev0;
        logic [7:0] d;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 32'h0);
        check("rst_dv", 32'(data_valid), 32'h0);
        check("rst_err", 32'(errors), 32'h0);
        check("rst_ev", 32'(errors_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        idle(500);
        check("idle_dv_n", 32'(dv_q.size()), 32'h0);
        check("idle_ev_n", 32'(ev_n), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_data", 32'(data), 32'h0);

        c0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(20);
        check("a5_dv_n", 32'(dv_q.size()), 32'd1);
        check("a5_val", 32'(dv_q[0]), 32'hA5);
        check("a5_data", 32'(data), 32'hA5);
        check("a5_ev_n", 32'(ev_n), 32'd0);
        check("a5_latency", 32'(dv_cyc - c0), 32'd171);
        check("a5_busy", 32'(busy), 32'h0);

        send_frame(8'h3C, 1'b1, 1'b1);
        idle(20);
        check("3c_ev_n", 32'(ev_n), 32'd1);
        check("3c_err", 32'(ev_last), 32'h1);
        check("3c_errors", 32'(errors), 32'h1);
        check("3c_dv_n", 32'(dv_q.size()), 32'd1);
        check("3c_data", 32'(data), 32'h3C);

        send_frame(8'h55, 1'b0, 1'b0);
        idle(OS);
        check("55_ev_n", 32'(ev_n), 32'd2);
        check("55_err", 32'(ev_last), 32'h2);
        check("55_dv_n", 32'(dv_q.size()), 32'd1);
        check("55_busy", 32'(busy), 32'h0);
        send_frame(8'h0F, 1'b0, 1'b1);
        idle(20);
        check("0f_dv_n", 32'(dv_q.size()), 32'd2);
        check("0f_val", 32'(dv_q[1]), 32'h0F);
        check("0f_ev_n", 32'(ev_n), 32'd2);

        send_frame(8'h00, 1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        check("brk_ev_n", 32'(ev_n), 32'd3);
        check("brk_err", 32'(errors), 32'h2);
        check("brk_busy", 32'(busy), 32'h1);
        check("brk_data", 32'(data), 32'h00);
        idle(20);
        check("brk_end_busy", 32'(busy), 32'h0);
        check("brk_end_ev_n", 32'(ev_n), 32'd3);
        check("brk_dv_n", 32'(dv_q.size()), 32'd2);

        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        check("glitch_busy_hi", 32'(busy), 32'h1);
        repeat (7) @(negedge clk);
        check("glitch_busy_lo", 32'(busy), 32'h0);
        idle(40);
        check("glitch_dv_n", 32'(dv_q.size()), 32'd2);
        check("glitch_ev_n", 32'(ev_n), 32'd3);

        send_frame(8'hDD, 1'b0, 1'b1);
        send_frame(8'hD1, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1);
        idle(20);
        check("b2b_dv_n", 32'(dv_q.size()), 32'd5);
        check("b2b_v0", 32'(dv_q[2]), 32'hDD);
        check("b2b_v1", 32'(dv_q[3]), 32'hD1);
        check("b2b_v2", 32'(dv_q[4]), 32'hAA);
        check("b2b_ev_n", 32'(ev_n), 32'd3);

        dv0 = dv_q.size();
        ev0 = ev_n;
        send_frame(8'hDD, 1'b0, 1'b1);
        d = 8'hD1;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rst_n = 1'b0;
        for (int i = 4; i < 8; i++) send_bit(d[i]);
        send_bit(1'b0);
        rx = 1'b1;
        repeat (OS / 2) @(negedge clk);
        check("mrst_data", 32'(data), 32'h0);
        check("mrst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (OS / 2) @(negedge clk);
        send_frame(8'hAA, 1'b0, 1'b1);
        idle(20);
        check("mrst_dv_n", 32'(dv_q.size() - dv0), 32'd2);
        check("mrst_v0", 32'(dv_q[dv0]), 32'hDD);
        check("mrst_v1", 32'(dv_q[dv0 + 1]), 32'hAA);
        check("mrst_ev_n", 32'(ev_n - ev0), 32'd0);
        check("never_both", 32'(both_n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
